w5300_bus_master: RTL
=====================

Name: w5300_bus_master

Overview:
- Executes single 16-bit register accesses on the W5300 direct-address parallel host bus (ADDR[9:0], DATA[15:0], CSn, RDn, WRn) on behalf of the IRQ handler and the other control FSMs.
- Sits directly downstream of w5300_irq_handler:
  - consumes its {rw, reg-address} command word and wr_data;
  - returns rd_data plus the one-cycle op_state completion strobe;
  - supplies a synchronised int_n.
- The upstream command source drives req from its not-idle indication (inverse of clear).

Parameters:
T_SETUP, 2, clk cycles with CSn low and address/data valid before the strobe falls (min 1)
T_STROBE, 3, clk cycles RDn/WRn held low (min 1)
T_HOLD, 1, clk cycles CSn/address/data held after the strobe rises (min 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  1  level request; sampled only in Idle
addr  in  11  command: [10] direction (W5300::WR = write, W5300::RD = read), [9:0] W5300 register address
wr_data  in  16  write data
rd_data  out  16  last read result
op_state  out  1  one-cycle pulse, access complete
busy  out  1  high in any state except Idle
int_n  in  1  raw W5300 INTn pin (asynchronous)
int_sync_n  out  1  int_n after 2-flop synchroniser
bus_addr  out  10  W5300 ADDR[9:0]
bus_data_o  out  16  W5300 DATA output value
bus_data_oe  out  1  DATA tristate enable, high = drive (tristate buffer lives in top level)
bus_data_i  in  16  W5300 DATA input value
bus_cs_n  out  1  W5300 CSn
bus_rd_n  out  1  W5300 RDn
bus_wr_n  out  1  W5300 WRn

Behaviour:
- Reset values (asserted asynchronously, immediately on rst):
  - state Idle;
  - bus_cs_n = bus_rd_n = bus_wr_n = 1, bus_data_oe = 0;
  - bus_addr = 0, bus_data_o = 0, rd_data = 0;
  - op_state = 0, busy = 0, int_sync_n = 1 (both sync flops preset to 1).
- All bus pins come straight from flops: no combinational glitches and no decode from state.
- FSM states: Idle, Setup, Strobe, Hold, Done. A single down-counter (width $clog2 of the max parameter + 1) times each phase.
- Idle, when req = 1 at an edge:
  - latch rw = addr[10], bus_addr = addr[9:0], bus_data_o = wr_data;
  - bus_cs_n <= 0, bus_data_oe <= rw;
  - go to Setup, cnt <= T_SETUP-1.
  - req = 0: remain in Idle.
- Setup: at cnt == 0:
  - drive bus_rd_n <= rw, bus_wr_n <= ~rw (the selected strobe goes low);
  - go to Strobe, cnt <= T_STROBE-1.
  - Otherwise cnt decrements.
- Strobe: at cnt == 0:
  - if read, rd_data <= bus_data_i (captured on the same edge the strobe rises);
  - bus_rd_n <= 1, bus_wr_n <= 1;
  - go to Hold, cnt <= T_HOLD-1.
- Hold: at cnt == 0:
  - bus_cs_n <= 1, bus_data_oe <= 0, op_state <= 1;
  - go to Done.
- Done: op_state <= 0; go to Idle. CSn is therefore high for at least 2 cycles between accesses.
- Latency:
  - op_state is high for exactly one cycle;
  - it rises T_SETUP+T_STROBE+T_HOLD edges after the accepting edge (6 with defaults).
  - The next access is accepted no earlier than 2 edges after op_state rises.
- Command inputs are sampled only on the accepting edge. Changes to addr, wr_data or req mid-access are ignored, and a started access always completes.
- rd_data is unchanged by write accesses. It holds until the next read completes, so it is valid in the op_state cycle and stays valid afterwards.
- bus_data_oe is never high while bus_rd_n is low.
- Reset mid-access aborts immediately to the reset values. No op_state is generated.
- int_sync_n is a 2-flop synchroniser of int_n, independent of the FSM.

Decomposition:
- Add to the W5300 package:
  - typedef enum for the bus FSM states;
  - default timing constants W5300_T_SETUP, W5300_T_STROBE, W5300_T_HOLD (used as parameter defaults).
- The existing RD/WR constants define addr[10].
- One sub-module: w5300_sync2 (generic 2-flop synchroniser, parameter RESET_VAL), instantiated for int_n.

Test Plan:
- Read, defaults: addr = {RD, 10'h002}, req pulsed one cycle; bus_data_i = 16'hA5C3 → CSn low 6 cycles, RDn low exactly 3 cycles starting 2 cycles after CSn, WRn stays 1, oe stays 0, rd_data = 16'hA5C3, op_state high one cycle 6 edges after accept.
- Write: addr = {WR, 10'h206}, wr_data = 16'hFFFF → bus_addr = 10'h206, bus_data_o = 16'hFFFF, oe high throughout CSn low, WRn low 3 cycles, rd_data unchanged, single op_state pulse.
- Back-to-back with req held high, upstream advancing addr on op_state → second access's CSn falls exactly 2 edges after op_state rises, and it carries the new address.
- Mid-access stimulus change: alter addr/wr_data/req during Strobe → bus pins keep latched values, access completes normally.
- Reset mid-Strobe: assert rst → CSn/RDn/WRn = 1, oe = 0 immediately (asynchronous, before the next edge), no op_state; after release, a new read completes normally.
- Parameter sweep T_SETUP = T_STROBE = T_HOLD = 1 → op_state 3 edges after accept. int_n fall → int_sync_n falls 2 edges later.

Source files
------------

// File: rtl/w5300_pkg.sv
// Shared W5300 host-bus definitions: access direction encoding, bus FSM states
// and default access timing (in clk cycles).
package w5300_pkg;

    // Direction bit carried in command bit [10]
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    localparam int W5300_T_SETUP  = 2;
    localparam int W5300_T_STROBE = 3;
    localparam int W5300_T_HOLD   = 1;

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_HOLD,
        BUS_DONE
    } bus_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/w5300_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input; both stages
// reset to RESET_VAL so the output is quiet while in reset.
module w5300_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_q, ff1_d;
    logic ff2_q, ff2_d;

    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q <= RESET_VAL;
            ff2_q <= RESET_VAL;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/w5300_bus_master.sv
// Single 16-bit register access engine for the W5300 direct-address host bus.
// Every bus pin is a flop output; one down-counter times setup, strobe and hold.
module w5300_bus_master
    import w5300_pkg::*;
#(
    parameter int T_SETUP  = W5300_T_SETUP,
    parameter int T_STROBE = W5300_T_STROBE,
    parameter int T_HOLD   = W5300_T_HOLD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [10:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        op_state,
    output logic        busy,
    input  logic        int_n,
    output logic        int_sync_n,
    output logic [9:0]  bus_addr,
    output logic [15:0] bus_data_o,
    output logic        bus_data_oe,
    input  logic [15:0] bus_data_i,
    output logic        bus_cs_n,
    output logic        bus_rd_n,
    output logic        bus_wr_n
);

    localparam int CNT_W = $clog2(max3(T_SETUP, T_STROBE, T_HOLD) + 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(T_HOLD - 1);

    bus_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic [9:0]       bus_addr_q, bus_addr_d;
    logic [15:0]      bus_data_o_q, bus_data_o_d;
    logic             bus_data_oe_q, bus_data_oe_d;
    logic             bus_cs_n_q, bus_cs_n_d;
    logic             bus_rd_n_q, bus_rd_n_d;
    logic             bus_wr_n_q, bus_wr_n_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic             op_state_q, op_state_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rw_d          = rw_q;
        bus_addr_d    = bus_addr_q;
        bus_data_o_d  = bus_data_o_q;
        bus_data_oe_d = bus_data_oe_q;
        bus_cs_n_d    = bus_cs_n_q;
        bus_rd_n_d    = bus_rd_n_q;
        bus_wr_n_d    = bus_wr_n_q;
        rd_data_d     = rd_data_q;
        op_state_d    = 1'b0;

        case (state_q)
            BUS_IDLE: begin
                if (req) begin
                    rw_d          = addr[10];
                    bus_addr_d    = addr[9:0];
                    bus_data_o_d  = wr_data;
                    bus_cs_n_d    = 1'b0;
                    bus_data_oe_d = (addr[10] == WR);
                    cnt_d         = SETUP_LOAD;
                    state_d       = BUS_SETUP;
                end
            end
            BUS_SETUP: begin
                if (cnt_q == '0) begin
                    bus_rd_n_d = (rw_q == WR);
                    bus_wr_n_d = (rw_q != WR);
                    cnt_d      = STROBE_LOAD;
                    state_d    = BUS_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BUS_STROBE: begin
                if (cnt_q == '0) begin
                    // Sample on the same edge that releases the strobe
                    if (rw_q == RD) begin
                        rd_data_d = bus_data_i;
                    end
                    bus_rd_n_d = 1'b1;
                    bus_wr_n_d = 1'b1;
                    cnt_d      = HOLD_LOAD;
                    state_d    = BUS_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BUS_HOLD: begin
                if (cnt_q == '0) begin
                    bus_cs_n_d    = 1'b1;
                    bus_data_oe_d = 1'b0;
                    op_state_d    = 1'b1;
                    state_d       = BUS_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BUS_DONE: begin
                state_d = BUS_IDLE;
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase

        busy_d = (state_d != BUS_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BUS_IDLE;
            cnt_q         <= '0;
            rw_q          <= RD;
            bus_addr_q    <= '0;
            bus_data_o_q  <= '0;
            bus_data_oe_q <= 1'b0;
            bus_cs_n_q    <= 1'b1;
            bus_rd_n_q    <= 1'b1;
            bus_wr_n_q    <= 1'b1;
            rd_data_q     <= '0;
            op_state_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rw_q          <= rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_data_o_q  <= bus_data_o_d;
            bus_data_oe_q <= bus_data_oe_d;
            bus_cs_n_q    <= bus_cs_n_d;
            bus_rd_n_q    <= bus_rd_n_d;
            bus_wr_n_q    <= bus_wr_n_d;
            rd_data_q     <= rd_data_d;
            op_state_q    <= op_state_d;
            busy_q        <= busy_d;
        end
    end

    w5300_sync2 #(
        .RESET_VAL(1'b1)
    ) u_int_sync (
        .clk(clk),
        .rst(rst),
        .d  (int_n),
        .q  (int_sync_n)
    );

    assign rd_data     = rd_data_q;
    assign op_state    = op_state_q;
    assign busy        = busy_q;
    assign bus_addr    = bus_addr_q;
    assign bus_data_o  = bus_data_o_q;
    assign bus_data_oe = bus_data_oe_q;
    assign bus_cs_n    = bus_cs_n_q;
    assign bus_rd_n    = bus_rd_n_q;
    assign bus_wr_n    = bus_wr_n_q;

endmodule
